// File: rtl/huff_node_sortn_if.sv
// Handshake and node bus between the tree-building controller and the node sorter.
// The master requests a sort; the slave (the sorter) returns the sorted nodes.
interface huff_node_sortn_if #(
    parameter int N        = 8,
    parameter int W_WEIGHT = 8,
    parameter int W_ID     = 5,
    parameter int NODE_W   = W_WEIGHT + W_ID,
    parameter int CW       = $clog2(N + 1)
);
    logic                sort_begin;
    logic [CW-1:0]       count;
    logic [N*NODE_W-1:0] nodes_in;
    logic [N*NODE_W-1:0] nodes_out;
    logic                busy;
    logic                sort_over;

    modport master (
        output sort_begin, count, nodes_in,
        input  nodes_out, busy, sort_over
    );

    modport slave (
        input  sort_begin, count, nodes_in,
        output nodes_out, busy, sort_over
    );
endinterface

// File: rtl/huff_node_sortn.sv
// N-slot Huffman node sorter: ascending, stable sort on the weight field using a
// sequential odd-even transposition network (one phase per cycle, fixed N+1 latency).
module huff_node_sortn #(
    parameter int N        = 8,
    parameter int W_WEIGHT = 8,
    parameter int W_ID     = 5,
    parameter int NODE_W   = W_WEIGHT + W_ID,
    parameter int CW       = $clog2(N + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    huff_node_sortn_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t              state_q;
    logic [NODE_W-1:0]   work_q   [N];
    logic [NODE_W-1:0]   work_nxt [N];
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       phase_q;
    logic [N*NODE_W-1:0] nodes_out_q;
    logic                busy_q;
    logic                over_q;

    // One transposition phase: even phases pair (0,1),(2,3)..., odd phases (1,2),(3,4)...
    always_comb begin
        // NOTE: every element gets a default before the conditional swaps, so no latch is inferred.
        for (int i = 0; i < N; i++) work_nxt[i] = work_q[i];
        for (int i = 0; i < N - 1; i++) begin
            if ((i[0] == phase_q[0]) && (CW'(i + 1) < cnt_q) &&
                (work_q[i][NODE_W-1:W_ID] > work_q[i+1][NODE_W-1:W_ID])) begin
                work_nxt[i]   = work_q[i+1];
                work_nxt[i+1] = work_q[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= '0;
            nodes_out_q <= '0;
            busy_q      <= 1'b0;
            over_q      <= 1'b0;
            // NOTE: the working array is a handful of flops, so it is reset with the control state.
            for (int i = 0; i < N; i++) work_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            case (state_q)
                IDLE: begin
                    over_q <= 1'b0;
                    if (bus.sort_begin) begin
                        for (int i = 0; i < N; i++) work_q[i] <= bus.nodes_in[i*NODE_W +: NODE_W];
                        cnt_q   <= (bus.count > CW'(N)) ? CW'(N) : bus.count;
                        phase_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SORT;
                    end
                end
                SORT: begin
                    for (int i = 0; i < N; i++) work_q[i] <= work_nxt[i];
                    phase_q <= phase_q + 1'b1;
                    if (phase_q == CW'(N - 1)) state_q <= DONE;
                end
                DONE: begin
                    for (int i = 0; i < N; i++) nodes_out_q[i*NODE_W +: NODE_W] <= work_q[i];
                    over_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.nodes_out = nodes_out_q;
    assign bus.busy      = busy_q;
    assign bus.sort_over = over_q;

endmodule

// File: doc/huff_node_sortn.md
Name: huff_node_sortn

Overview:
- Parametrised N-entry sorter for Huffman tree nodes; the generalised successor of the fixed 3-node sorter.
- Captures up to N packed nodes (weight + symbol/ID) on a start pulse and sorts them ascending by weight. It uses a sequential odd-even transposition network.
- Sits between the frequency counter / node merger and the tree builder. Output slot 0 is the lowest-weight node, i.e. the next merge candidate.

Parameters:
- N, 8: number of node slots; must be >= 2.
- W_WEIGHT, 8: weight field width; occupies node bits [NODE_W-1:W_ID].
- W_ID, 5: symbol/ID field width; occupies node bits [W_ID-1:0].
- NODE_W, W_WEIGHT+W_ID: derived node width; not to be overridden.
- CW, $clog2(N+1): width of the count port.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- sort_begin  in  1  start request; sampled only in IDLE.
- count  in  CW  number of valid nodes, packed from slot 0; values > N are clamped to N.
- nodes_in  in  N*NODE_W  slot i at bits [i*NODE_W +: NODE_W].
- nodes_out  out  N*NODE_W  sorted result, same packing as nodes_in.
- busy  out  1  high from the cycle after sort_begin is accepted until sort_over.
- sort_over  out  1  one-cycle pulse when nodes_out is valid.

Behaviour:
- Reset (async, nRST=0):
  - FSM goes to IDLE.
  - nodes_out, working array, busy and sort_over all go to 0.
  - A reset mid-sort aborts with no sort_over pulse.
- States: IDLE, SORT, DONE.
- IDLE:
  - With sort_begin=1 at edge k, nodes_in goes to the working array and min(count,N) goes to the count register.
  - Phase counter is cleared, busy goes to 1, state goes to SORT.
  - sort_begin=0 holds IDLE.
- SORT, one phase per cycle:
  - Edges k+1 .. k+N execute phases p=0..N-1.
  - Even p compares pairs (0,1),(2,3),...; odd p compares pairs (1,2),(3,4),...
  - A pair (i,i+1) swaps only if i+1 < count and weight[i] > weight[i+1], strictly greater.
  - Equal weights never swap, so the sort is stable: equal-weight nodes keep input order.
  - Compare on the weight field only; the ID never affects ordering.
  - After phase N-1, state goes to DONE.
- DONE, edge k+N+1:
  - nodes_out is loaded from the working array, sort_over=1 for exactly one cycle, busy goes to 0, state goes to IDLE.
  - Latency is fixed: sort_over is high in the cycle after edge k+N+1, i.e. N+1 cycles after sort_begin is sampled, regardless of count or data.
- Slots >= count:
  - Never participate in a swap; passed through unchanged to nodes_out.
- count = 0 or 1:
  - Full latency still applies; the data is unchanged.
- sort_begin while busy (SORT/DONE):
  - Ignored, not queued. nodes_in/count changes during SORT have no effect.
- Back-to-back operation:
  - sort_begin may be asserted in the sort_over cycle. It is accepted because the FSM is in IDLE at that edge.
- nodes_out:
  - Holds its last result until the next DONE.
  - Not updated at load or during SORT; only reset or DONE change it.
- No arithmetic on weights: comparisons are unsigned, W_WEIGHT bits wide.

Test Plan:
- Reset and idle:
  - Stimulus: assert nRST=0 mid-SORT with N=8.
  - Required: busy=0, sort_over=0, nodes_out=0 immediately. No sort_over pulse after release.
- Full sort:
  - Stimulus: N=8, count=8, weights slot0..7 = 9,3,7,1,8,2,6,4, IDs 0..7.
  - Required: sort_over 9 cycles after sort_begin. Weights out = 1,2,3,4,6,7,8,9; IDs = 3,5,1,7,6,2,4,0.
- Stability:
  - Stimulus: weights 5,5,2,5,2,0,0,0 with count=5, IDs 0..7.
  - Required: out weights 2,2,5,5,5,0,0,0. IDs 2,4,0,1,3,5,6,7 (equal weights keep input order; slots 5-7 untouched).
- Partial count and clamp:
  - Stimulus: count=3 with weights 200,10,50,1,... Then repeat with count=15.
  - Required for count=3: out 10,50,200,1,... with slot 3 onward unchanged.
  - Required for count=15: behaves as count=8.
- Busy handling:
  - Stimulus: pulse sort_begin again at cycle 4 of a sort, with changed nodes_in.
  - Required: exactly one sort_over; result reflects only the first data.
- Back-to-back:
  - Stimulus: assert sort_begin in the sort_over cycle with new data.
  - Required: a second sort_over 9 cycles later. nodes_out holds the first result until then.
